// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the multiplier arbiter: FSM state encoding,
// datapath widths and default sizing.
package mult_arb_pkg;

    localparam int OPER_W          = 16;
    localparam int PROD_W          = 32;
    localparam int NUM_REQ_DEF     = 4;
    localparam int TIMEOUT_CYC_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    // Index/counter width that stays at least one bit for degenerate sizes.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Round-robin grant selection: scans the request vector starting one past the
// previous winner and returns the first hit as one-hot plus index.
module rr_grant
    import mult_arb_pkg::*;
#(
    parameter int  NUM_REQ = NUM_REQ_DEF,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [IDX_W-1:0] cand_s;
    logic             hit_s;

    // Rotating priority scan; the first requester found after last_grant wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand_s      = '0;
        hit_s       = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand_s        = IDX_W'((int'(last_grant) + off) % NUM_REQ);
            hit_s         = req[cand_s] && !grant_valid;
            grant[cand_s] = grant[cand_s] | hit_s;
            grant_idx     = hit_s ? cand_s : grant_idx;
            grant_valid   = grant_valid | hit_s;
        end
    end

endmodule

// File: rtl/multiply_arbiter.sv
// Shares one external sequential multiplier among NUM_REQ requesters with
// round-robin arbitration, a result timeout and a one-cycle response pulse.
module multiply_arbiter
    import mult_arb_pkg::*;
#(
    parameter int  NUM_REQ     = NUM_REQ_DEF,
    parameter int  TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    localparam int IDX_W       = idx_width(NUM_REQ)
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0][OPER_W-1:0] req_A,
    input  logic [NUM_REQ-1:0][OPER_W-1:0] req_B,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [OPER_W-1:0]              mul_A,
    output logic [OPER_W-1:0]              mul_B,
    output logic                           mul_start,
    input  logic [PROD_W-1:0]              mul_product,
    input  logic                           mul_READY,
    output logic                           rsp_valid,
    output logic [IDX_W-1:0]               rsp_id,
    output logic [PROD_W-1:0]              rsp_product,
    output logic                           rsp_error
);

    localparam int CNT_W = idx_width(TIMEOUT_CYC);

    arb_state_e         state_r, state_s;
    logic [NUM_REQ-1:0] grant_oh_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic               grant_valid_s;
    logic               ready_ok_s;
    logic               timeout_s;

    logic [NUM_REQ-1:0] req_ready_r,   req_ready_s;
    logic [OPER_W-1:0]  mul_a_r,       mul_a_s;
    logic [OPER_W-1:0]  mul_b_r,       mul_b_s;
    logic               mul_start_r,   mul_start_s;
    logic               rsp_valid_r,   rsp_valid_s;
    logic [IDX_W-1:0]   rsp_id_r,      rsp_id_s;
    logic [PROD_W-1:0]  rsp_product_r, rsp_product_s;
    logic               rsp_error_r,   rsp_error_s;
    logic [CNT_W-1:0]   wait_cnt_r,    wait_cnt_s;
    logic [IDX_W-1:0]   last_grant_r,  last_grant_s;
    logic [IDX_W-1:0]   cur_id_r,      cur_id_s;

    rr_grant #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_grant (
        .req         (req_valid),
        .last_grant  (last_grant_r),
        .grant       (grant_oh_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_valid_s)
    );

    // The first two WAIT cycles are blind so a stale READY from the multiplier
    // cannot be mistaken for the result of the operation just started.
    assign ready_ok_s = mul_READY && (wait_cnt_r >= CNT_W'(2));
    assign timeout_s  = (wait_cnt_r == CNT_W'(TIMEOUT_CYC - 1));

    // State register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_s = ST_WAIT;
            ST_WAIT: begin
                if (ready_ok_s || timeout_s) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; data registers hold by default.
    always_comb begin
        req_ready_s   = '0;
        mul_start_s   = 1'b0;
        rsp_valid_s   = 1'b0;
        mul_a_s       = mul_a_r;
        mul_b_s       = mul_b_r;
        rsp_id_s      = rsp_id_r;
        rsp_product_s = rsp_product_r;
        rsp_error_s   = rsp_error_r;
        wait_cnt_s    = wait_cnt_r;
        last_grant_s  = last_grant_r;
        cur_id_s      = cur_id_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    req_ready_s  = grant_oh_s;
                    mul_a_s      = req_A[grant_idx_s];
                    mul_b_s      = req_B[grant_idx_s];
                    last_grant_s = grant_idx_s;
                    cur_id_s     = grant_idx_s;
                end else begin
                    wait_cnt_s = '0;
                end
            end
            ST_ISSUE: begin
                mul_start_s = 1'b1;
                wait_cnt_s  = '0;
            end
            ST_WAIT: begin
                wait_cnt_s = wait_cnt_r + CNT_W'(1);
                if (ready_ok_s) begin
                    rsp_valid_s   = 1'b1;
                    rsp_id_s      = cur_id_r;
                    rsp_product_s = mul_product;
                    rsp_error_s   = 1'b0;
                end else if (timeout_s) begin
                    rsp_valid_s   = 1'b1;
                    rsp_id_s      = cur_id_r;
                    rsp_product_s = '0;
                    rsp_error_s   = 1'b1;
                end else begin
                    rsp_valid_s = 1'b0;
                end
            end
            ST_RESP: rsp_valid_s = 1'b0;
            default: rsp_valid_s = 1'b0;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            req_ready_r   <= '0;
            mul_a_r       <= '0;
            mul_b_r       <= '0;
            mul_start_r   <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_id_r      <= '0;
            rsp_product_r <= '0;
            rsp_error_r   <= 1'b0;
            wait_cnt_r    <= '0;
            last_grant_r  <= IDX_W'(NUM_REQ - 1);
            cur_id_r      <= '0;
        end else begin
            req_ready_r   <= req_ready_s;
            mul_a_r       <= mul_a_s;
            mul_b_r       <= mul_b_s;
            mul_start_r   <= mul_start_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_id_r      <= rsp_id_s;
            rsp_product_r <= rsp_product_s;
            rsp_error_r   <= rsp_error_s;
            wait_cnt_r    <= wait_cnt_s;
            last_grant_r  <= last_grant_s;
            cur_id_r      <= cur_id_s;
        end
    end

    assign req_ready   = req_ready_r;
    assign mul_A       = mul_a_r;
    assign mul_B       = mul_b_r;
    assign mul_start   = mul_start_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_id      = rsp_id_r;
    assign rsp_product = rsp_product_r;
    assign rsp_error   = rsp_error_r;

endmodule

// File: tb/tb_multiply_arbiter.sv
// Self-checking bench for multiply_arbiter with a behavioural sequential
// multiplier of programmable latency and a round-robin reference model.
module tb_multiply_arbiter;

    localparam int TO = 32;

    logic             CLK = 1'b0;
    logic             RESET;
    logic [3:0]       req_valid;
    logic [3:0][15:0] req_A;
    logic [3:0][15:0] req_B;
    logic [3:0]       req_ready;
    logic [15:0]      mul_A;
    logic [15:0]      mul_B;
    logic             mul_start;
    logic [31:0]      mul_product;
    logic             mul_READY;
    logic             rsp_valid;
    logic [1:0]       rsp_id;
    logic [31:0]      rsp_product;
    logic             rsp_error;

    int checks   = 0;
    int failures = 0;
    int last_g   = 3;
    int mul_lat  = 16;
    int mul_rem;
    logic [31:0] mdl_prod;

    multiply_arbiter #(
        .NUM_REQ     (4),
        .TIMEOUT_CYC (TO)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .req_valid   (req_valid),
        .req_A       (req_A),
        .req_B       (req_B),
        .req_ready   (req_ready),
        .mul_A       (mul_A),
        .mul_B       (mul_B),
        .mul_start   (mul_start),
        .mul_product (mul_product),
        .mul_READY   (mul_READY),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .rsp_error   (rsp_error)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] smul(input logic [15:0] a, input logic [15:0] b);
        int ia;
        int ib;
        ia = int'($signed(a));
        ib = int'($signed(b));
        return 32'(ia * ib);
    endfunction

    // sequential_multiply stand-in: READY pulses mul_lat cycles after the
    // start pulse is sampled; mul_lat = 0 models a multiplier that never answers.
    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mul_rem  <= 0;
            mdl_prod <= 32'd0;
        end else if (mul_start) begin
            mul_rem  <= mul_lat;
            mdl_prod <= smul(mul_A, mul_B);
        end else if (mul_rem > 0) begin
            mul_rem <= mul_rem - 1;
        end
    end
    assign mul_READY   = (mul_rem == 1);
    assign mul_product = mul_READY ? mdl_prod : 32'hDEAD_BEEF;

    function automatic int rr_pick(input int last, input logic [3:0] v);
        for (int k = 1; k <= 4; k++) begin
            if (v[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction: grant, issue, wait, response, then hold check.
    task automatic run_op(input logic [3:0] vld, input int lat, output int g_obs);
        int          g_exp;
        int          cyc;
        logic [15:0] ea;
        logic [15:0] eb;
        logic        err_exp;
        logic [31:0] prod_exp;
        logic [1:0]  gid;
        logic        hold_ok;
        mul_lat  = lat;
        g_exp    = rr_pick(last_g, vld);
        gid      = g_exp[1:0];
        ea       = req_A[gid];
        eb       = req_B[gid];
        err_exp  = (lat == 0) || (lat > TO - 1);
        prod_exp = err_exp ? 32'd0 : smul(ea, eb);
        req_valid = vld;
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (req_ready == 4'd0 && cyc < 8);
        chk("grant_seen", {63'd0, (req_ready != 4'd0)}, 64'd1);
        g_obs = -1;
        for (int i = 0; i < 4; i++) begin
            if (req_ready[i]) g_obs = i;
        end
        chk("req_ready_onehot", {60'd0, req_ready}, {60'd0, 4'b0001 << gid});
        @(negedge CLK);
        chk("issue_pulse", {42'd0, req_ready, mul_start, mul_A}, {42'd0, 4'd0, 1'b1, ea});
        chk("issue_mul_B", {48'd0, mul_B}, {48'd0, eb});
        hold_ok = 1'b1;
        cyc = 0;
        while (cyc < TO + 8) begin
            @(negedge CLK);
            cyc++;
            if (rsp_valid) break;
            if (mul_start || req_ready != 4'd0 || mul_A !== ea || mul_B !== eb) hold_ok = 1'b0;
        end
        chk("wait_stable", {63'd0, hold_ok}, 64'd1);
        chk("latency", 64'(cyc), 64'(err_exp ? TO : lat + 1));
        chk("rsp_fields", {29'd0, rsp_valid, rsp_id, rsp_error, rsp_product},
                          {29'd0, 1'b1, gid, err_exp, prod_exp});
        @(negedge CLK);
        chk("rsp_hold", {29'd0, rsp_valid, rsp_id, rsp_error, rsp_product},
                        {29'd0, 1'b0, gid, err_exp, prod_exp});
        last_g = g_exp;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int seen;
        int seq4[5]  = '{0, 1, 2, 3, 0};
        int seq13[4] = '{3, 1, 3, 1};
        logic [3:0] v;
        int lat;

        RESET     = 1'b0;
        req_valid = 4'd0;
        req_A     = '0;
        req_B     = '0;
        repeat (2) @(negedge CLK);
        chk("reset_outputs", {req_ready, mul_A, mul_B, mul_start, rsp_valid, rsp_id, rsp_error},
                             {4'd0, 16'd0, 16'd0, 1'b0, 1'b0, 2'd0, 1'b0});
        chk("reset_product", {32'd0, rsp_product}, 64'd0);
        RESET = 1'b1;
        @(negedge CLK);

        // Four-way contention held: grants rotate from requester 0.
        for (int i = 0; i < 4; i++) begin
            req_A[i] = 16'(100 + i);
            req_B[i] = 16'(i) - 16'd3;
        end
        for (int i = 0; i < 5; i++) begin
            run_op(4'b1111, 16, g);
            chk("rr4_grant", 64'(g), 64'(seq4[i]));
        end

        // Single requester: 3 * -7.
        req_A[0] = 16'd3;
        req_B[0] = 16'hFFF9;
        run_op(4'b0001, 16, g);
        chk("mul_3x-7_id", 64'(g), 64'd0);
        chk("mul_3x-7_prod", {32'd0, rsp_product}, {32'd0, 32'hFFFF_FFEB});

        // Requesters 1 and 3 alternate after a grant to 1.
        run_op(4'b0010, 16, g);
        chk("grant_1_only", 64'(g), 64'd1);
        for (int i = 0; i < 4; i++) begin
            run_op(4'b1010, 16, g);
            chk("rr13_grant", 64'(g), 64'(seq13[i]));
        end

        // Multiplier never answers: timeout response.
        run_op(4'b0100, 0, g);
        chk("timeout_err", {63'd0, rsp_error}, 64'd1);
        // Latest acceptable READY still yields a valid product.
        run_op(4'b0100, TO - 1, g);
        chk("late_ready_ok", {63'd0, rsp_error}, 64'd0);

        // Most negative operands through requester 2.
        req_A[2] = 16'h8000;
        req_B[2] = 16'h8000;
        run_op(4'b0100, 16, g);
        chk("minmin_id", {62'd0, rsp_id}, 64'd2);
        chk("minmin_prod", {32'd0, rsp_product}, {32'd0, 32'h4000_0000});
        req_valid = 4'd0;
        @(negedge CLK);

        // Asynchronous reset while waiting on the multiplier.
        mul_lat   = 16;
        req_valid = 4'b0001;
        seen = 0;
        while (req_ready == 4'd0 && seen < 8) begin
            @(negedge CLK);
            seen++;
        end
        req_valid = 4'd0;
        repeat (5) @(negedge CLK);
        #2 RESET = 1'b0;
        #1;
        chk("async_reset_outputs", {req_ready, mul_A, mul_B, mul_start, rsp_valid, rsp_id, rsp_error},
                                   {4'd0, 16'd0, 16'd0, 1'b0, 1'b0, 2'd0, 1'b0});
        chk("async_reset_product", {32'd0, rsp_product}, 64'd0);
        @(negedge CLK);
        RESET = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge CLK);
            if (rsp_valid || mul_start) seen++;
        end
        chk("no_rsp_after_reset", 64'(seen), 64'd0);
        last_g = 3;
        run_op(4'b1111, 16, g);
        chk("post_reset_grant", 64'(g), 64'd0);

        // Randomized operations against the reference model.
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 4; i++) begin
                req_A[i] = 16'($urandom);
                req_B[i] = 16'($urandom);
            end
            v = 4'($urandom_range(1, 15));
            case ($urandom_range(0, 19))
                0:       lat = 0;
                1:       lat = TO - 1;
                2:       lat = TO;
                default: lat = $urandom_range(2, 12);
            endcase
            run_op(v, lat, g);
            if ($urandom_range(0, 7) == 0) begin
                req_valid = 4'd0;
                repeat ($urandom_range(1, 3)) @(negedge CLK);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
